// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-port bundle between the datapath, the arbiter and the RAM.
// slave is the arbiter's view; master is the requester-plus-RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/ram_arbiter.sv
// Serialises instruction and data requests onto one variable-latency RAM port,
// alternating under contention, with a per-access timeout and sticky error flag.
module ram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          CLK,
  input  logic          RST,
  ram_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic G_INSTR = 1'b0;
  localparam logic G_DATA  = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              err_q, err_d;

  logic want_i, want_d;
  assign want_i = bus.iREN;
  assign want_d = bus.dREN | bus.dWEN;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    store_d = store_q;
    cnt_d   = cnt_q;
    iload_d = iload_q;
    dload_d = dload_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (want_i || want_d) begin
          // Under contention the side that lost last time wins.
          gnt_d   = want_d && (!want_i || last_q == G_INSTR);
          last_d  = gnt_d;
          wr_d    = gnt_d & bus.dWEN;
          addr_d  = gnt_d ? bus.daddr : bus.iaddr;
          store_d = bus.dstore;
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.ram_ready) begin
          if (gnt_q == G_INSTR) iload_d = bus.ramload;
          else if (!wr_q)       dload_d = bus.ramload;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LIM) begin
          err_d = 1'b1;
          if (gnt_q == G_INSTR) iload_d = '0;
          else                  dload_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= G_INSTR;
      last_q  <= G_INSTR;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      cnt_q   <= '0;
      iload_q <= '0;
      dload_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      err_q   <= err_d;
    end
  end

  assign bus.ramREN   = (state_q == S_ACCESS) && !wr_q;
  assign bus.ramWEN   = (state_q == S_ACCESS) && wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = (state_q == S_RESP) && (gnt_q == G_INSTR);
  assign bus.dhit     = (state_q == S_RESP) && (gnt_q == G_DATA);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (TIMEOUT_CYC=4); outputs sampled 1 time unit after each rising edge.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.ram_ready = 1'b0;
  endtask

  initial begin
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0;
    clr_req();
    rst = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_ramREN", bus.ramREN, 0);
    chk("rst_ramWEN", bus.ramWEN, 0);
    chk("rst_ihit",   bus.ihit, 0);
    chk("rst_dhit",   bus.dhit, 0);
    chk("rst_err",    bus.err, 0);
    chk("rst_iload",  bus.iload, 0);
    chk("rst_dload",  bus.dload, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    rst = 1'b0;

    // instruction read, ready in second strobe cycle
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    tick();
    chk("i1_ramREN_c1", bus.ramREN, 1);
    chk("i1_ramWEN_c1", bus.ramWEN, 0);
    chk("i1_ramaddr",   bus.ramaddr, 32'h40);
    chk("i1_ihit_c1",   bus.ihit, 0);
    tick();
    chk("i1_ramREN_c2", bus.ramREN, 1);
    bus.ram_ready = 1'b1; bus.ramload = 32'h3C01_0004;
    tick();
    chk("i1_ihit",   bus.ihit, 1);
    chk("i1_dhit",   bus.dhit, 0);
    chk("i1_iload",  bus.iload, 32'h3C01_0004);
    chk("i1_ramREN_resp", bus.ramREN, 0);
    clr_req();
    tick();
    chk("i1_ihit_done", bus.ihit, 0);
    chk("i1_iload_hold", bus.iload, 32'h3C01_0004);

    // data write, immediate ready
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEAD_BEEF;
    tick();
    chk("w_ramWEN",   bus.ramWEN, 1);
    chk("w_ramREN",   bus.ramREN, 0);
    chk("w_ramaddr",  bus.ramaddr, 32'h100);
    chk("w_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    bus.ram_ready = 1'b1; bus.ramload = 32'h1234_5678;
    tick();
    chk("w_dhit",   bus.dhit, 1);
    chk("w_ihit",   bus.ihit, 0);
    chk("w_ramWEN_resp", bus.ramWEN, 0);
    chk("w_dload_unch", bus.dload, 0);
    clr_req();
    tick();

    // contention from reset: DATA, INSTR, DATA, INSTR
    rst = 1'b1;
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h80; bus.daddr = 32'h200;
    bus.ram_ready = 1'b1; bus.ramload = 32'h5555_0001;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk($sformatf("c%0d_ramaddr", g), bus.ramaddr, (g % 2 == 0) ? 32'h200 : 32'h80);
      chk($sformatf("c%0d_ramREN", g), bus.ramREN, 1);
      tick();
      chk($sformatf("c%0d_dhit", g), bus.dhit, (g % 2 == 0) ? 1 : 0);
      chk($sformatf("c%0d_ihit", g), bus.ihit, (g % 2 == 0) ? 0 : 1);
      if (g == 3) clr_req();
      tick();
      chk($sformatf("c%0d_idle_hits", g), {bus.ihit, bus.dhit}, 0);
    end
    chk("c_dload", bus.dload, 32'h5555_0001);
    chk("c_iload", bus.iload, 32'h5555_0001);

    // dREN and dWEN together: a single write
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h8; bus.dstore = 32'hCAFE_0008;
    bus.ramload = 32'h9999_9999;
    tick();
    chk("rw_ramWEN",  bus.ramWEN, 1);
    chk("rw_ramREN",  bus.ramREN, 0);
    chk("rw_ramaddr", bus.ramaddr, 32'h8);
    bus.ram_ready = 1'b1;
    tick();
    chk("rw_dhit", bus.dhit, 1);
    chk("rw_dload_unch", bus.dload, 32'h5555_0001);
    clr_req();
    tick();
    chk("rw_single_dhit", bus.dhit, 0);

    // reset during a data read, pending iREN served afterwards
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    tick();
    chk("mr_ramREN", bus.ramREN, 1);
    rst = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h44;
    tick();
    chk("mr_strobes", {bus.ramREN, bus.ramWEN}, 0);
    chk("mr_dhit", bus.dhit, 0);
    chk("mr_dload", bus.dload, 0);
    rst = 1'b0; bus.dREN = 1'b0;
    tick();
    chk("mr_i_ramREN",  bus.ramREN, 1);
    chk("mr_i_ramaddr", bus.ramaddr, 32'h44);
    chk("mr_no_dhit",   bus.dhit, 0);
    bus.ram_ready = 1'b1; bus.ramload = 32'h1111_2222;
    tick();
    chk("mr_ihit",  bus.ihit, 1);
    chk("mr_dhit2", bus.dhit, 0);
    chk("mr_iload", bus.iload, 32'h1111_2222);
    clr_req();
    tick();

    // timeout with TIMEOUT_CYC=4
    chk("to_err_pre", bus.err, 0);
    bus.iREN = 1'b1; bus.iaddr = 32'h60;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to_ramREN_%0d", c), bus.ramREN, 1);
      chk($sformatf("to_ihit_%0d", c), bus.ihit, 0);
    end
    tick();
    chk("to_ihit",  bus.ihit, 1);
    chk("to_ramREN_off", bus.ramREN, 0);
    chk("to_iload", bus.iload, 0);
    chk("to_err",   bus.err, 1);
    clr_req();
    tick();
    chk("to_err_hold", bus.err, 1);

    // later successful read keeps err set
    bus.dREN = 1'b1; bus.daddr = 32'h10;
    tick();
    chk("pr_ramaddr", bus.ramaddr, 32'h10);
    bus.ram_ready = 1'b1; bus.ramload = 32'h77;
    tick();
    chk("pr_dhit",  bus.dhit, 1);
    chk("pr_dload", bus.dload, 32'h77);
    chk("pr_err",   bus.err, 1);
    clr_req();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
